// File: rtl/pipe_csel_adder.sv
// Pipelined carry-select adder/subtractor.
// One BLK-bit segment is resolved per stage. Each stage forms both candidate
// segment sums and picks one with the carry registered by the previous stage,
// so no carry ripples across a stage boundary inside a single cycle.
// Operands travel with the carry (skew delay), and the finished low segments
// travel with them too, so a complete result leaves the last stage at once.
module pipe_csel_adder #(
   parameter int WIDTH = 32,
   parameter int BLK   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam bit PARAMS_OK = (BLK >= 1) && (WIDTH >= BLK) &&
                              ((WIDTH % ((BLK >= 1) ? BLK : 1)) == 0);
   localparam int NSEG      = PARAMS_OK ? (WIDTH / BLK) : 1;

   if (!PARAMS_OK) begin : g_param_check
      $error("pipe_csel_adder: WIDTH must be a nonzero multiple of BLK, BLK >= 1");
   end

   // The whole pipeline advances together; it only freezes when a result
   // is waiting at the output and the consumer is not taking it.
   logic en;
   assign en       = !out_valid || out_ready;
   assign in_ready = en && !rst;

   logic             vld_reg [NSEG];
   logic             cy_reg  [NSEG];
   logic [WIDTH-1:0] a_reg   [NSEG];
   logic [WIDTH-1:0] bx_reg  [NSEG];
   logic [WIDTH-1:0] sum_reg [NSEG];
   logic             ovf_reg;
   logic             ovf_next;

   genvar gi;
   for (gi = 0; gi < NSEG; gi++) begin : g_stage
      localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({BLK{1'b1}}) << (gi * BLK);

      logic             v_in;
      logic             c_in;
      logic [WIDTH-1:0] a_in;
      logic [WIDTH-1:0] bx_in;
      logic [WIDTH-1:0] s_in;
      logic [BLK:0]     seg_c0;
      logic [BLK:0]     seg_c1;
      logic [BLK:0]     seg_sel;
      logic [WIDTH-1:0] s_next;

      if (gi == 0) begin : g_head
         // Subtraction is folded in up front: invert B, and the borrow-in
         // becomes an inverted carry-in.
         assign v_in  = in_valid;
         assign a_in  = a;
         assign bx_in = b ^ {WIDTH{sub}};
         assign c_in  = cin ^ sub;
         assign s_in  = '0;
      end else begin : g_body
         assign v_in  = vld_reg[gi-1];
         assign a_in  = a_reg[gi-1];
         assign bx_in = bx_reg[gi-1];
         assign c_in  = cy_reg[gi-1];
         assign s_in  = sum_reg[gi-1];
      end

      // Both candidate sums for this segment, then selection by incoming carry.
      assign seg_c0  = {1'b0, a_in[gi*BLK +: BLK]} + {1'b0, bx_in[gi*BLK +: BLK]};
      assign seg_c1  = seg_c0 + (BLK+1)'(1);
      assign seg_sel = c_in ? seg_c1 : seg_c0;
      assign s_next  = (s_in & ~SEG_MASK) | (WIDTH'(seg_sel[BLK-1:0]) << (gi * BLK));

      if (gi == NSEG - 1) begin : g_tail
         // Carry into the MSB is recovered as a ^ bx ^ sum at that bit.
         assign ovf_next = a_in[WIDTH-1] ^ bx_in[WIDTH-1] ^ seg_sel[BLK-1] ^ seg_sel[BLK];
      end

      // Stage register: valid bit, segment carry, skewed operands, partial sum.
      always_ff @(posedge clk) begin
         if (rst) begin
            vld_reg[gi] <= 1'b0;
            cy_reg[gi]  <= 1'b0;
            a_reg[gi]   <= '0;
            bx_reg[gi]  <= '0;
            sum_reg[gi] <= '0;
         end else if (en) begin
            vld_reg[gi] <= v_in;
            cy_reg[gi]  <= seg_sel[BLK];
            a_reg[gi]   <= a_in;
            bx_reg[gi]  <= bx_in;
            sum_reg[gi] <= s_next;
         end
      end
   end

   // Overflow flag is produced alongside the final segment.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_reg <= 1'b0;
      end else if (en) begin
         ovf_reg <= ovf_next;
      end
   end

   assign out_valid = vld_reg[NSEG-1];
   assign sum       = sum_reg[NSEG-1];
   assign cout      = cy_reg[NSEG-1];
   assign ovf       = ovf_reg;

endmodule

// File: doc/pipe_csel_adder.md
PIPE_CSEL_ADDER -- requirements
Module: pipe_csel_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand and sum width in bits.
REQ-002 The block SHALL have parameter BLK, default 8: segment width in bits; NSEG = WIDTH/BLK.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: synchronous active-high reset.
REQ-006 Port in_valid, input, 1: operands on a/b/cin/sub are valid.
REQ-007 Port in_ready, output, 1: block accepts an operation this cycle.
REQ-008 Port a, input, WIDTH: operand A.
REQ-009 Port b, input, WIDTH: operand B.
REQ-010 Port cin, input, 1: carry-in, or borrow-in when sub=1.
REQ-011 Port sub, input, 1: 0 = add, 1 = subtract.
REQ-012 Port out_valid, output, 1: sum/cout/ovf hold a result.
REQ-013 Port out_ready, input, 1: consumer takes the result this cycle.
REQ-014 Port sum, output, WIDTH: result.
REQ-015 Port cout, output, 1: carry out of bit WIDTH-1; in subtract mode 1 = no borrow.
REQ-016 Port ovf, output, 1: two's-complement signed overflow.

Function
REQ-017 Elaboration SHALL fail unless BLK>=1 and WIDTH is a nonzero multiple of BLK.
REQ-018 Result SHALL equal a + (b XOR {WIDTH{sub}}) + (cin XOR sub), truncated to WIDTH bits; carry out goes to cout.
REQ-019 ovf SHALL equal carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-020 Pipeline SHALL have NSEG stages; stage k computes segment k (bits k*BLK+BLK-1..k*BLK) only.
REQ-021 Each stage SHALL compute both the carry-0 and carry-1 segment sums/carries combinationally, then select by the registered carry from stage k-1; stage 0 selects by cin XOR sub.
REQ-022 No carry SHALL cross a stage boundary combinationally; inter-stage carry is registered.
REQ-023 Operand segments for stages 1..NSEG-1 SHALL be skew-delayed; completed low segments SHALL be delayed so all segments of one operation emerge together.
REQ-024 Latency SHALL be exactly NSEG cycles from acceptance (in_valid & in_ready) to out_valid, with out_ready held high.
REQ-025 Throughput SHALL be one operation per cycle with out_ready high; ordering SHALL be preserved.
REQ-026 Global advance enable en = !out_valid | out_ready; in_ready = en & !rst.
REQ-027 When en=0 every stage register, per-stage valid bit and output SHALL hold.
REQ-028 When en=1 and in_valid=0, a bubble (valid bit 0) SHALL enter stage 0.
REQ-029 sum/cout/ovf SHALL stay stable while out_valid=1 and out_ready=0.
REQ-030 With NSEG=1 the block SHALL act as a single registered carry-select adder with latency 1.

Reset
REQ-031 While rst=1 on a clock edge: all per-stage valid bits, out_valid, sum, cout and ovf SHALL be 0, and in_ready SHALL be 0.
REQ-032 Operations in flight when rst asserts SHALL be discarded and SHALL never appear on the output.
REQ-033 In the first cycle after rst deasserts, in_ready SHALL be 1.

Verification (WIDTH=32, BLK=8, latency 4)
REQ-034 Reset: rst high 2 cycles -> out_valid=0, sum=0, cout=0, ovf=0; in_ready=1 in the first cycle after release.
REQ-035 Full ripple: a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> 4 cycles later sum=0x00000000, cout=1, ovf=0.
REQ-036 Overflow: a=0x7FFFFFFF, b=0x00000001, cin=0, sub=0 -> sum=0x80000000, cout=0, ovf=1; subtract a=5, b=7, sub=1, cin=0 -> sum=0xFFFFFFFE, cout=0, ovf=0.
REQ-037 Backpressure: 8 back-to-back ops, out_ready low for 3 cycles from cycle 6 -> in_ready low during the stall; all 8 results correct, in order, no loss or duplication.
REQ-038 Reset mid-flight: 3 ops accepted, rst pulsed 1 cycle -> no result from those ops appears; the next op after reset completes in 4 cycles.
REQ-039 Random: 10k random a/b/cin/sub with random in_valid/out_ready -> every result matches the REQ-018/019 model.
